// File: rtl/wave_gen_pkg.sv
// Shared types for the wave generator: waveform select and ramp direction.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAW_UP   = 2'd1,
    SAW_DOWN = 2'd2,
    SQUARE   = 2'd3
  } wave_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/wave_generator_if.sv
// Control/observation bundle between a wave_generator and the logic that programs it.
interface wave_generator_if #(parameter int N = 8);
  import wave_gen_pkg::*;

  logic             ena;
  wave_mode_t       mode;
  logic [N-1:0]     lo;
  logic [N-1:0]     hi;
  logic [N-1:0]     step;
  logic [N-1:0]     out;
  logic             period_pulse;

  modport master (
    output ena, mode, lo, hi, step,
    input  out, period_pulse
  );

  modport slave (
    input  ena, mode, lo, hi, step,
    output out, period_pulse
  );

endinterface

// File: rtl/adder_n.sv
// Plain W-bit ripple adder with carry in/out; {o_cout, o_sum} is the W+1-bit result.
module adder_n #(parameter int W = 8) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/wave_generator_sat_step.sv
// One saturating step: a+step clamped to bound (sub=0) or a-step clamped to bound (sub=1).
module sat_step #(parameter int N = 8) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] step,
  input  logic [N-1:0] bound,
  input  logic         sub,
  output logic [N-1:0] result
);

  logic [N-1:0] w_b;
  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_clamp;

  assign w_b = sub ? ~step : step;

  adder_n #(.W(N)) u_adder (
    .i_a    (a),
    .i_b    (w_b),
    .i_cin  (sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // When subtracting, a carry-out of 1 means no borrow occurred.
  assign w_clamp = sub ? (!w_cout || (w_sum < bound))
                       : ( w_cout || (w_sum > bound));
  assign result  = w_clamp ? bound : w_sum;

endmodule

// File: rtl/wave_generator.sv
// Enable-gated periodic waveform source (triangle, saw up/down, square) with
// programmable bounds and step, plus a period-start strobe.
module wave_generator
  import wave_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  wave_generator_if.slave bus
);

  logic [N-1:0] r_count;
  dir_t         r_dir;
  logic         r_pulse;
  logic [N-1:0] r_out;

  logic [N-1:0] w_up;
  logic [N-1:0] w_down;
  logic [N-1:0] w_count_nxt;
  dir_t         w_dir_nxt;
  logic         w_pulse_nxt;
  logic [N-1:0] w_out_nxt;
  logic         w_degenerate;
  logic         w_out_of_range;

  sat_step #(.N(N)) u_step_up (
    .a(r_count), .step(bus.step), .bound(bus.hi), .sub(1'b0), .result(w_up)
  );

  sat_step #(.N(N)) u_step_down (
    .a(r_count), .step(bus.step), .bound(bus.lo), .sub(1'b1), .result(w_down)
  );

  assign w_degenerate   = (bus.lo >= bus.hi);
  assign w_out_of_range = (r_count < bus.lo) || (r_count > bus.hi);

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_pulse_nxt = 1'b0;

    if (w_degenerate || w_out_of_range) begin
      w_count_nxt = bus.lo;
      w_dir_nxt   = DIR_UP;
    end else if (bus.step != '0) begin
      case (bus.mode)
        TRIANGLE, SQUARE: begin
          if (r_dir == DIR_UP) begin
            w_count_nxt = w_up;
            if (w_up == bus.hi) w_dir_nxt = DIR_DOWN;
          end else begin
            w_count_nxt = w_down;
            if (w_down == bus.lo) begin
              w_dir_nxt   = DIR_UP;
              w_pulse_nxt = 1'b1;
            end
          end
        end
        SAW_UP: begin
          if (r_count == bus.hi) begin
            w_count_nxt = bus.lo;
            w_pulse_nxt = 1'b1;
          end else begin
            w_count_nxt = w_up;
          end
        end
        SAW_DOWN: begin
          if (r_count == bus.lo) begin
            w_count_nxt = bus.hi;
            w_pulse_nxt = 1'b1;
          end else begin
            w_count_nxt = w_down;
          end
        end
      endcase
    end

    // Square shows the half-period level; degenerate bounds already force count=lo, dir=UP.
    if (bus.mode == SQUARE) w_out_nxt = (w_dir_nxt == DIR_DOWN) ? bus.hi : bus.lo;
    else                    w_out_nxt = w_count_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (rst) begin
      r_count <= bus.lo;
      r_dir   <= DIR_UP;
      r_pulse <= 1'b0;
      r_out   <= bus.lo;
    end else if (bus.ena) begin
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_pulse <= w_pulse_nxt;
      r_out   <= w_out_nxt;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign bus.out          = r_out;
  assign bus.period_pulse = r_pulse;

endmodule

// File: tb/tb_wave_generator.sv
// Self-checking bench for wave_generator: directed sequences with literal expectations
// plus a long randomized run compared cycle by cycle against a behavioural model.
module tb_wave_generator;
  import wave_gen_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  wave_generator_if #(.N(N)) bus ();

  wave_generator #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: value-level rules with plain integer arithmetic.
  int m_count;
  bit m_rising;
  int m_out;
  bit m_pulse;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int l, h, s, c, up_v, down_v;
    l = int'(bus.lo);
    h = int'(bus.hi);
    s = int'(bus.step);
    c = m_count;
    if (rst) begin
      m_count  = l;
      m_rising = 1'b1;
      m_pulse  = 1'b0;
      m_out    = l;
      m_valid  = 1'b1;
    end else if (bus.ena) begin
      up_v    = (c + s > h) ? h : c + s;
      down_v  = (c - s < l) ? l : c - s;
      m_pulse = 1'b0;
      if (l >= h || c < l || c > h) begin
        m_count  = l;
        m_rising = 1'b1;
      end else if (s != 0) begin
        if (bus.mode == TRIANGLE || bus.mode == SQUARE) begin
          if (m_rising) begin
            m_count = up_v;
            if (up_v == h) m_rising = 1'b0;
          end else begin
            m_count = down_v;
            if (down_v == l) begin
              m_rising = 1'b1;
              m_pulse  = 1'b1;
            end
          end
        end else if (bus.mode == SAW_UP) begin
          if (c == h) begin m_count = l; m_pulse = 1'b1; end
          else m_count = up_v;
        end else begin
          if (c == l) begin m_count = h; m_pulse = 1'b1; end
          else m_count = down_v;
        end
      end
      m_out = (bus.mode == SQUARE) ? (m_rising ? l : h) : m_count;
    end else begin
      m_pulse = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      check("model_out", 32'(bus.out), 32'(m_out));
      check("model_pulse", 32'(bus.period_pulse), 32'(m_pulse));
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic expect_now(input string name, input int v, input bit p);
    check({name, "_out"}, 32'(bus.out), 32'(v));
    check({name, "_pulse"}, 32'(bus.period_pulse), 32'(p));
    check({name, "_mdl"}, 32'(m_out), 32'(v));
  endtask

  task automatic expect_next(input string name, input int v, input bit p);
    @(negedge clk);
    expect_now(name, v, p);
  endtask

  // Called just after a negedge with inputs already set; returns at the negedge after reset.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setup(input wave_mode_t md, input int l, input int h, input int s);
    bus.mode = md;
    bus.lo   = N'(l);
    bus.hi   = N'(h);
    bus.step = N'(s);
    bus.ena  = 1'b1;
  endtask

  initial begin
    int a, b;
    setup(TRIANGLE, 0, 3, 1);
    rst = 1'b1;
    @(negedge clk);

    // Triangle 0..3, then freeze on the pulse cycle, then reset while enabled.
    do_reset();
    expect_now("tri_rst", 0, 0);
    expect_next("tri", 1, 0);
    expect_next("tri", 2, 0);
    expect_next("tri", 3, 0);
    expect_next("tri", 2, 0);
    expect_next("tri", 1, 0);
    expect_next("tri", 0, 1);
    bus.ena = 1'b0;
    expect_next("hold", 0, 0);
    expect_next("hold", 0, 0);
    expect_next("hold", 0, 0);
    bus.ena = 1'b1;
    expect_next("resume", 1, 0);
    expect_next("resume", 2, 0);
    rst = 1'b1;
    expect_next("rst_ena", 0, 0);
    rst = 1'b0;

    // Sawtooth up, then sawtooth down from the same state.
    @(negedge clk);
    setup(SAW_UP, 10, 20, 4);
    do_reset();
    expect_now("saw_up_rst", 10, 0);
    expect_next("saw_up", 14, 0);
    expect_next("saw_up", 18, 0);
    expect_next("saw_up", 20, 0);
    expect_next("saw_up", 10, 1);
    expect_next("saw_up", 14, 0);
    bus.mode = SAW_DOWN;
    expect_next("saw_dn", 10, 0);
    expect_next("saw_dn", 20, 1);
    expect_next("saw_dn", 16, 0);
    expect_next("saw_dn", 12, 0);
    expect_next("saw_dn", 10, 0);
    expect_next("saw_dn", 20, 1);

    // Square: four cycles low, four high, pulse on return to lo.
    @(negedge clk);
    setup(SQUARE, 5, 200, 50);
    do_reset();
    expect_now("sq_rst", 5, 0);
    expect_next("sq", 5, 0);
    expect_next("sq", 5, 0);
    expect_next("sq", 5, 0);
    expect_next("sq", 200, 0);
    expect_next("sq", 200, 0);
    expect_next("sq", 200, 0);
    expect_next("sq", 200, 0);
    expect_next("sq", 5, 1);
    expect_next("sq", 5, 0);

    // Full-range triangle with a big step: saturates, never wraps.
    @(negedge clk);
    setup(TRIANGLE, 0, 255, 200);
    do_reset();
    expect_now("sat_rst", 0, 0);
    expect_next("sat", 200, 0);
    expect_next("sat", 255, 0);
    expect_next("sat", 55, 0);
    expect_next("sat", 0, 1);
    expect_next("sat", 200, 0);

    // Live hi reduction below the current count resyncs to lo.
    @(negedge clk);
    setup(TRIANGLE, 0, 100, 20);
    do_reset();
    expect_next("live", 20, 0);
    expect_next("live", 40, 0);
    expect_next("live", 60, 0);
    expect_next("live", 80, 0);
    bus.hi = N'(40);
    expect_next("live_resync", 0, 0);
    expect_next("live", 20, 0);
    expect_next("live", 40, 0);
    expect_next("live", 20, 0);
    expect_next("live", 0, 1);

    // Degenerate lo == hi: constant output, no pulse, in every mode.
    @(negedge clk);
    setup(SAW_UP, 7, 7, 3);
    do_reset();
    expect_now("degen_rst", 7, 0);
    expect_next("degen", 7, 0);
    bus.mode = SQUARE;
    expect_next("degen", 7, 0);
    bus.mode = SAW_DOWN;
    expect_next("degen", 7, 0);

    // Randomized run; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 199) == 0);
      bus.ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) bus.mode = wave_mode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        if ($urandom_range(0, 9) != 0 && a > b) begin
          bus.lo = N'(b);
          bus.hi = N'(a);
        end else begin
          bus.lo = N'(a);
          bus.hi = N'(b);
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) bus.step = N'($urandom_range(0, 255));
        else                           bus.step = N'($urandom_range(0, 12));
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
